program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Program loader: streams instruction words into program memory, optionally pads the rest
// with HALT words (LOADER_HALT_FILL_EN), then releases the core via core_run.
module program_loader #(
  parameter int                    INST_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [INST_WIDTH-1:0] HALT_WORD  = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [INST_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  core_run,
  output logic                  busy,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   loaded_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   wptr, wptr_next;
  logic [ADDR_WIDTH:0]     count, count_next;
  logic                    error_q, error_next;
  logic                    we_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [INST_WIDTH-1:0]   wdata_next;
  logic                    accept;

  assign in_ready     = (state == LOAD);
  assign busy         = (state == LOAD) || (state == FILL);
  assign accept       = in_valid && (state == LOAD);
  assign error        = error_q;
  assign loaded_count = count;

  always_comb begin
    state_next = state;
    wptr_next  = wptr;
    count_next = count;
    error_next = error_q;
    we_next    = 1'b0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    unique case (state)
      IDLE, RUN: begin
        if (start) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
          error_next = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = wptr;
          wdata_next = in_data;
          count_next = count + 1'b1;
          // wptr saturates at the last address so an overflow never wraps onto word 0
          if (wptr != LAST_ADDR) begin
            wptr_next = wptr + 1'b1;
          end
          if (in_last) begin
`ifdef LOADER_HALT_FILL_EN
            state_next = (wptr == LAST_ADDR) ? RUN : FILL;
`else
            state_next = RUN;
`endif
          end else if (wptr == LAST_ADDR) begin
            state_next = IDLE;
            error_next = 1'b1;
          end
        end
      end
`ifdef LOADER_HALT_FILL_EN
      FILL: begin
        we_next    = 1'b1;
        addr_next  = wptr;
        wdata_next = HALT_WORD;
        if (wptr == LAST_ADDR) begin
          state_next = RUN;
        end else begin
          wptr_next = wptr + 1'b1;
        end
      end
`endif
      default: begin
        // FILL is unreachable without the fill feature; recover to IDLE without writing
        state_next = IDLE;
        wdata_next = HALT_WORD;
      end
    endcase
  end

  // core_run follows the next state so it is registered yet high exactly while in RUN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wptr      <= '0;
      count     <= '0;
      error_q   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_run  <= 1'b0;
    end else begin
      state     <= state_next;
      wptr      <= wptr_next;
      count     <= count_next;
      error_q   <= error_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      core_run  <= (state_next == RUN);
    end
  end

endmodule
